gate_delay_meter: RTL and testbench

GATE_DELAY_METER -- requirements
Module: gate_delay_meter

---
 rtl/gate_delay_meter.sv | 111 +++++++++++
 tb/tb_gate_delay_meter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_delay_meter.sv
// Measures the delay, in clock cycles, from a stimulus edge to the next change of the gate output.
// Each result is held on a valid/ready interface until the consumer accepts it.
module gate_delay_meter #(
  parameter int unsigned CW      = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stim,
  input  logic          resp,
  input  logic          resp_z,
  output logic          meas_valid,
  input  logic          meas_ready,
  output logic [1:0]    meas_kind,
  output logic [CW-1:0] meas_cycles,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam logic [CW-1:0] TimeoutC = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e        state_q, state_d;
  logic          stim_q;
  logic [1:0]    base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [1:0]    kind_q, kind_d;
  logic [7:0]    drop_q, drop_d;
  logic          drop_inc;
  logic          stim_edge;
  logic [1:0]    rs;

  assign stim_edge = stim ^ stim_q;
  // Z overrides the sampled level so rs only takes the values 00, 01 and 10.
  assign rs        = {resp_z, resp & ~resp_z};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    kind_d   = kind_q;
    drop_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stim_edge) begin
          base_d  = rs;
          cnt_d   = CW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (rs != base_q) begin
          cycles_d = cnt_q;
          kind_d   = rs[1] ? 2'd2 : (rs[0] ? 2'd0 : 2'd1);
          state_d  = StHold;
          drop_inc = stim_edge;
        end else if (cnt_q == TimeoutC) begin
          cycles_d = TimeoutC;
          kind_d   = 2'd3;
          state_d  = StHold;
          drop_inc = stim_edge;
        end else if (stim_edge) begin
          // A new edge before any response abandons the old measurement.
          base_d   = rs;
          cnt_d    = CW'(1);
          drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StHold: begin
        drop_inc = stim_edge;
        if (meas_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    drop_d = (drop_inc && (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      stim_q   <= 1'b0;
      base_q   <= 2'b00;
      cnt_q    <= '0;
      cycles_q <= '0;
      kind_q   <= 2'd0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      kind_q   <= kind_d;
      drop_q   <= drop_d;
    end
  end

  assign meas_valid  = (state_q == StHold);
  assign busy        = (state_q == StWait) || (state_q == StHold);
  assign meas_kind   = kind_q;
  assign meas_cycles = cycles_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_gate_delay_meter.sv
// Scoreboard bench for gate_delay_meter: expected results are queued as stimulus is driven
// and compared when the DUT hands a result over.
module tb_gate_delay_meter;

  localparam int unsigned CW      = 8;
  localparam int unsigned TIMEOUT = 5;

  typedef struct {
    int kind;
    int cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stim;
  logic          resp;
  logic          resp_z;
  logic          meas_valid;
  logic          meas_ready;
  logic [1:0]    meas_kind;
  logic [CW-1:0] meas_cycles;
  logic          busy;
  logic [7:0]    drop_cnt;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  gate_delay_meter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stim        (stim),
    .resp        (resp),
    .resp_z      (resp_z),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_kind   (meas_kind),
    .meas_cycles (meas_cycles),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an edge, wait d cycles, change the response, then let the DUT report it.
  task automatic measure(input int d, input logic r, input logic z, input int kind);
    exp_t e;
    e.kind   = kind;
    e.cycles = d;
    exp_q.push_back(e);
    stim = ~stim;
    repeat (d) tick();
    resp   = r;
    resp_z = z;
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    check_val("idle_bound", int'(busy), 0);
  endtask

  // Scoreboard: pop on every accepted transfer.
  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("kind", int'(meas_kind), e.kind);
        check_val("cycles", int'(meas_cycles), e.cycles);
      end
    end
  end

  initial begin
    int d0;
    int k0;
    int c0;
    exp_t e;
    rst        = 1'b1;
    stim       = 1'b0;
    resp       = 1'b0;
    resp_z     = 1'b0;
    meas_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", int'(meas_valid), 0);
    check_val("rst_kind", int'(meas_kind), 0);
    check_val("rst_cycles", int'(meas_cycles), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Rise: reported three cycles after the edge, valid for exactly one cycle.
    measure(3, 1'b1, 1'b0, 0);
    check_val("rise_valid", int'(meas_valid), 1);
    check_val("rise_busy", int'(busy), 1);
    tick();
    check_val("rise_valid_drop", int'(meas_valid), 0);
    check_val("rise_idle", int'(busy), 0);

    // Fall, then turn-off.
    measure(2, 1'b0, 1'b0, 1);
    wait_idle();
    measure(3, 1'b0, 1'b1, 2);
    wait_idle();
    resp_z = 1'b0;
    tick();

    // Minimum delay of one cycle.
    measure(1, 1'b1, 1'b0, 0);
    wait_idle();

    // Timeout with a constant response.
    e.kind   = 3;
    e.cycles = TIMEOUT;
    exp_q.push_back(e);
    stim = ~stim;
    repeat (TIMEOUT) tick();
    check_val("to_not_yet", int'(meas_valid), 0);
    check_val("to_busy", int'(busy), 1);
    tick();
    check_val("to_valid", int'(meas_valid), 1);
    wait_idle();

    // Backpressure with two edges dropped while holding.
    meas_ready = 1'b0;
    d0 = int'(drop_cnt);
    measure(1, 1'b0, 1'b0, 1);
    k0 = int'(meas_kind);
    c0 = int'(meas_cycles);
    for (int i = 0; i < 4; i++) begin
      check_val("bp_valid", int'(meas_valid), 1);
      check_val("bp_kind_stable", int'(meas_kind), k0);
      check_val("bp_cycles_stable", int'(meas_cycles), c0);
      if (i == 0 || i == 2) stim = ~stim;
      tick();
    end
    check_val("bp_drop", int'(drop_cnt), d0 + 2);
    meas_ready = 1'b1;
    tick();
    check_val("bp_released", int'(meas_valid), 0);
    wait_idle();

    // Restart: second edge two cycles after the first.
    d0 = int'(drop_cnt);
    stim = ~stim;
    repeat (2) tick();
    measure(3, 1'b1, 1'b0, 0);
    check_val("rs_drop", int'(drop_cnt), d0 + 1);
    wait_idle();

    // Reset in the middle of a wait abandons the measurement.
    stim = ~stim;
    repeat (2) tick();
    check_val("mid_busy", int'(busy), 1);
    rst  = 1'b1;
    stim = 1'b0;
    tick();
    check_val("mr_busy", int'(busy), 0);
    check_val("mr_drop", int'(drop_cnt), 0);
    check_val("mr_valid", int'(meas_valid), 0);
    rst = 1'b0;
    repeat (8) tick();
    check_val("mr_no_result", int'(meas_valid), 0);

    // Stim held high through reset is an edge right after release.
    rst  = 1'b1;
    stim = 1'b1;
    tick();
    e.kind   = 3;
    e.cycles = TIMEOUT;
    exp_q.push_back(e);
    rst = 1'b0;
    tick();
    check_val("held_edge_busy", int'(busy), 1);
    wait_idle();

    check_val("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
